// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, FSM states,
// control-vector bit positions and trap cause codes.
package cpu_ctrl_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam int unsigned CTRL_W        = 11;
    localparam int unsigned CB_REG_WRITE  = 10;
    localparam int unsigned CB_MEM_WR     = 9;
    localparam int unsigned CB_MEM_RD     = 8;
    localparam int unsigned CB_BRANCH     = 7;
    localparam int unsigned CB_MEM_TO_REG = 6;
    localparam int unsigned CB_JAL        = 5;
    localparam int unsigned CB_IMM_TO_REG = 4;
    localparam int unsigned CB_ALU_SRC_A  = 3;
    localparam int unsigned CB_ALU_SRC_B  = 2;
    localparam int unsigned CB_PC_TO_REG  = 1;
    localparam int unsigned CB_CMP_BRANCH = 0;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

endpackage

// File: rtl/control_decode.sv
// Combinational RV32I opcode decoder: opcode -> 11-bit control vector and
// an illegal-opcode flag.
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0]        opcode_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o
);

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;
        case (opcode_i)
            OPC_JAL,
            OPC_JALR:   ctrl_o = 11'b100_1010_1110;
            OPC_LUI:    ctrl_o = 11'b100_0001_0000;
            OPC_AUIPC:  ctrl_o = 11'b100_0000_1100;
            OPC_BRANCH: ctrl_o = 11'b000_1000_1101;
            OPC_STORE:  ctrl_o = 11'b010_0000_0000;
            OPC_LOAD:   ctrl_o = 11'b101_0100_0100;
            OPC_OPIMM:  ctrl_o = 11'b100_0000_0100;
            OPC_OP:     ctrl_o = 11'b100_0000_0000;
            default:    illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with variable-latency memory
// handshakes, state-qualified control outputs and sticky trap reporting.
module multi_cycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = $clog2(WAIT_MAX + 1)
) (
    input  logic              clk_w_i,
    input  logic              rst_w_i_l,
    input  logic [6:0]        opcode_w_i,
    input  logic              imem_ack_w_i_h,
    input  logic              dmem_ack_w_i_h,
    output logic              imem_req_w_o_h,
    output logic              dmem_req_w_o_h,
    output logic              ir_write_w_o_h,
    output logic              pc_write_w_o_h,
    output logic [CTRL_W-1:0] ctrl_w_o,
    output logic              fault_w_o_h,
    output logic [1:0]        fault_cause_w_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic [1:0]        cause_q, cause_d;

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_illegal;
    logic              timeout;

    control_decode u_decode (
        .opcode_i  (opcode_w_i),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign timeout = (cnt_q == CNT_W'(WAIT_MAX));

    // Ack wins over timeout: the ack branch is tested first in both wait states.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        ctrl_d    = ctrl_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        cause_d   = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack_w_i_h) begin
                    ctrl_d    = dec_ctrl;
                    illegal_d = dec_illegal;
                    state_d   = ST_DECODE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_IMEM_TO;
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                if (illegal_q) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = (ctrl_q[CB_MEM_WR] || ctrl_q[CB_MEM_RD]) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (dmem_ack_w_i_h) begin
                    state_d = ST_WB;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    cause_d = CAUSE_DMEM_TO;
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
        if (!rst_w_i_l) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
            cause_q   <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            cause_q   <= cause_d;
        end
    end

    // Reset sits in FETCH, so the fetch-side outputs are gated by reset itself;
    // ir_write follows ack because the instruction word is valid only in that cycle.
    assign imem_req_w_o_h = rst_w_i_l && (state_q == ST_FETCH);
    assign ir_write_w_o_h = rst_w_i_l && (state_q == ST_FETCH) && imem_ack_w_i_h;
    assign dmem_req_w_o_h = (state_q == ST_MEM);
    assign pc_write_w_o_h = (state_q == ST_WB);
    assign fault_w_o_h     = fault_q;
    assign fault_cause_w_o = cause_q;

    always_comb begin
        ctrl_w_o = '0;
        if (state_q != ST_TRAP) begin
            ctrl_w_o = ctrl_q;
            if (state_q != ST_WB) begin
                ctrl_w_o[CB_REG_WRITE] = 1'b0;
            end
            if (state_q != ST_MEM) begin
                ctrl_w_o[CB_MEM_WR] = 1'b0;
                ctrl_w_o[CB_MEM_RD] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: a vector table of whole instructions
// plus hand-written reset, illegal-opcode and timeout sequences.
module tb_multi_cycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, iack, dack;
    logic [6:0]  opc;
    logic        ireq, dreq, irw, pcw, flt;
    logic [10:0] ctrl;
    logic [1:0]  cause;

    logic        rst3_n, iack3, dack3;
    logic [6:0]  opc3;
    logic        ireq3, dreq3, irw3, pcw3, flt3;
    logic [10:0] ctrl3;
    logic [1:0]  cause3;

    multi_cycle_control dut (
        .clk_w_i(clk), .rst_w_i_l(rst_n), .opcode_w_i(opc),
        .imem_ack_w_i_h(iack), .dmem_ack_w_i_h(dack),
        .imem_req_w_o_h(ireq), .dmem_req_w_o_h(dreq),
        .ir_write_w_o_h(irw), .pc_write_w_o_h(pcw),
        .ctrl_w_o(ctrl), .fault_w_o_h(flt), .fault_cause_w_o(cause)
    );

    multi_cycle_control #(.WAIT_MAX(3)) dut3 (
        .clk_w_i(clk), .rst_w_i_l(rst3_n), .opcode_w_i(opc3),
        .imem_ack_w_i_h(iack3), .dmem_ack_w_i_h(dack3),
        .imem_req_w_o_h(ireq3), .dmem_req_w_o_h(dreq3),
        .ir_write_w_o_h(irw3), .pc_write_w_o_h(pcw3),
        .ctrl_w_o(ctrl3), .fault_w_o_h(flt3), .fault_cause_w_o(cause3)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [6:0]  op;
        int          idly;
        int          ddly;
        bit          is_mem;
        logic [10:0] wb_ctrl;
        logic [10:0] mem_ctrl;
    } vec_t;

    vec_t vecs[11];

    // Runs one instruction on dut, starting at posedge+1 with dut in FETCH.
    task automatic run_instr(input vec_t v);
        int icnt = 0, dcnt = 0, ir_c = -1, ir_n = 0, pc_c = -1, dn = 0;
        int mem_bad = 0, mask_bad = 0;
        logic [10:0] wb = '0;
        bit done = 0;
        int exp_last;
        exp_last = 3 + v.idly + (v.is_mem ? 1 + v.ddly : 0);
        for (int c = 0; c < 60 && !done; c++) begin
            opc  = v.op;
            iack = ireq && (icnt == v.idly);
            dack = dreq && (dcnt == v.ddly);
            @(negedge clk);
            if (irw) begin ir_c = c; ir_n++; end
            if (pcw) begin pc_c = c; wb = ctrl; done = 1; end
            if (dreq) begin
                dn++;
                if (ctrl !== v.mem_ctrl) mem_bad++;
            end
            if (!dreq && (ctrl[9] || ctrl[8])) mask_bad++;
            if (!pcw && ctrl[10]) mask_bad++;
            if (ireq) icnt++;
            if (dreq) dcnt++;
            @(posedge clk); #1;
        end
        iack = 1'b0;
        dack = 1'b0;
        chk({v.name, "_completed"}, 32'(done), 1);
        chk({v.name, "_wb_cycle"}, pc_c, exp_last);
        chk({v.name, "_ir_cycle"}, ir_c, v.idly);
        chk({v.name, "_ir_pulses"}, ir_n, 1);
        chk({v.name, "_wb_ctrl"}, 32'(wb), 32'(v.wb_ctrl));
        chk({v.name, "_mem_cycles"}, dn, v.is_mem ? v.ddly + 1 : 0);
        chk({v.name, "_mem_ctrl"}, mem_bad, 0);
        chk({v.name, "_ctrl_masking"}, mask_bad, 0);
    endtask

    initial begin
        int first_f, cnt_bad, ir_c, pc_n, dn;

        vecs[0]  = '{"op",        7'b0110011, 0,  0,  0, 11'b100_0000_0000, 11'b0};
        vecs[1]  = '{"load_d3",   7'b0000011, 0,  3,  1, 11'b100_0100_0100, 11'b001_0100_0100};
        vecs[2]  = '{"store",     7'b0100011, 0,  0,  1, 11'b000_0000_0000, 11'b010_0000_0000};
        vecs[3]  = '{"branch",    7'b1100011, 0,  0,  0, 11'b000_1000_1101, 11'b0};
        vecs[4]  = '{"jal_i1",    7'b1101111, 1,  0,  0, 11'b100_1010_1110, 11'b0};
        vecs[5]  = '{"jalr",      7'b1100111, 0,  0,  0, 11'b100_1010_1110, 11'b0};
        vecs[6]  = '{"lui_i2",    7'b0110111, 2,  0,  0, 11'b100_0001_0000, 11'b0};
        vecs[7]  = '{"auipc",     7'b0010111, 0,  0,  0, 11'b100_0000_1100, 11'b0};
        vecs[8]  = '{"opimm",     7'b0010011, 0,  0,  0, 11'b100_0000_0100, 11'b0};
        vecs[9]  = '{"load_max",  7'b0000011, 15, 15, 1, 11'b100_0100_0100, 11'b001_0100_0100};
        vecs[10] = '{"store_max", 7'b0100011, 3,  15, 1, 11'b000_0000_0000, 11'b010_0000_0000};

        rst_n = 0; iack = 0; dack = 0; opc = '0;
        rst3_n = 0; iack3 = 0; dack3 = 0; opc3 = '0;
        #1;
        chk("in_reset_outputs", {ireq, dreq, irw, pcw, ctrl, flt, cause}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_imem_req", 32'(ireq), 1);
        chk("rst_other_outputs", {dreq, irw, pcw, ctrl, flt, cause}, 0);
        @(posedge clk); #1;

        foreach (vecs[i]) run_instr(vecs[i]);

        // Reset while waiting in MEM for a LOAD.
        opc = 7'b0000011; iack = 1;
        @(negedge clk);
        @(posedge clk); #1; iack = 0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid_mem_dmem_req", 32'(dreq), 1);
        chk("mid_mem_ctrl", 32'(ctrl), 32'(11'b001_0100_0100));
        #2 rst_n = 0;
        #1;
        chk("mid_mem_reset_outputs", {ireq, dreq, irw, pcw, ctrl, flt, cause}, 0);
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk);
        chk("after_reset_imem_req", 32'(ireq), 1);
        chk("after_reset_rest", {dreq, pcw, ctrl, flt, cause}, 0);
        @(posedge clk); #1;

        // Illegal opcode traps after DECODE and stays there.
        opc = 7'b0000000; iack = 1;
        @(negedge clk);
        chk("illegal_ir_write", 32'(irw), 1);
        @(posedge clk); #1; iack = 0;
        @(negedge clk);
        chk("illegal_decode_no_fault", 32'(flt), 0);
        @(negedge clk);
        chk("illegal_fault", 32'(flt), 1);
        chk("illegal_cause", 32'(cause), 1);
        cnt_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1; iack = c[0]; dack = c[1];
            @(negedge clk);
            if (ireq || dreq || irw || pcw || ctrl != 0 || !flt || cause != 2'b01) cnt_bad++;
        end
        iack = 0; dack = 0;
        chk("trap_held_20_cycles", cnt_bad, 0);

        // WAIT_MAX=3: imem never acks.
        @(posedge clk); #1; rst3_n = 1;
        first_f = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 3) chk("to3_req_at_cycle3", 32'(ireq3), 1);
            if (flt3 && first_f < 0) first_f = c;
            @(posedge clk); #1;
        end
        chk("imem_timeout_cycle", first_f, 4);
        chk("imem_timeout_cause", 32'(cause3), 2);
        chk("imem_timeout_req_low", 32'(ireq3), 0);

        // Ack exactly at the limit succeeds; then a LOAD whose dmem never acks.
        rst3_n = 0;
        @(posedge clk); #1; rst3_n = 1;
        first_f = -1; ir_c = -1; pc_n = 0; dn = 0;
        for (int c = 0; c < 18; c++) begin
            iack3 = (c == 3) || (c == 7);
            opc3  = (c < 7) ? 7'b0110011 : 7'b0000011;
            @(negedge clk);
            if (irw3 && ir_c < 0) ir_c = c;
            if (pcw3) pc_n++;
            if (dreq3) dn++;
            if (flt3 && first_f < 0) first_f = c;
            @(posedge clk); #1;
        end
        iack3 = 0;
        chk("ack_at_limit_ir_cycle", ir_c, 3);
        chk("ack_at_limit_wb_count", pc_n, 1);
        chk("dmem_wait_cycles", dn, 4);
        chk("dmem_timeout_cycle", first_f, 14);
        chk("dmem_timeout_cause", 32'(cause3), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
